// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: runs a WIDTH-bit (4*NIBBLES) operation on an external 4-bit
// 74181-style ALU, one nibble per cycle LSB first, chaining carry between
// slices and collecting F, the top-nibble carry-out and a whole-word A==B flag.
module ula_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic [3:0]           req_s,
  input  logic                 req_m,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_f,
  output logic                 rsp_cout,
  output logic                 rsp_a_eq_b,
  output logic                 busy,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cin,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cout,
  input  logic                 alu_a_eq_b
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, f_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;
  logic             eq_acc_reg;
  logic             cout_reg;
  logic             a_eq_b_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             last_nib;
  logic             inv_carry;

  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];

  // Split the captured operands into per-slice nibbles for the idx mux.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign last_nib = (idx_reg == LAST_IDX);

  // Arithmetic codes for which the ALU's carry-out comes back inverted.
  always_comb begin
    inv_carry = 1'b0;
    if (!m_reg) begin
      case (s_reg)
        4'b0000, 4'b0010, 4'b0011,
        4'b0110, 4'b0111, 4'b1011: inv_carry = 1'b1;
        default:                   inv_carry = 1'b0;
      endcase
    end
  end

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state and handshake / ALU drive; ALU lines idle at zero outside RUN.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b0;
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_s      = 4'h0;
    alu_m      = 1'b0;
    alu_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        alu_a   = a_nib[idx_reg];
        alu_b   = b_nib[idx_reg];
        alu_s   = s_reg;
        alu_m   = m_reg;
        alu_cin = m_reg ? 1'b0 : carry_reg;
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-slice result collection and carry chaining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      f_reg      <= '0;
      s_reg      <= 4'h0;
      m_reg      <= 1'b0;
      carry_reg  <= 1'b0;
      eq_acc_reg <= 1'b0;
      cout_reg   <= 1'b0;
      a_eq_b_reg <= 1'b0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            a_reg      <= req_a;
            b_reg      <= req_b;
            s_reg      <= req_s;
            m_reg      <= req_m;
            carry_reg  <= req_cin;
            idx_reg    <= '0;
            eq_acc_reg <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) f_reg[4*i +: 4] <= alu_f;
          end
          eq_acc_reg <= eq_acc_reg & alu_a_eq_b;
          if (m_reg)          carry_reg <= 1'b0;
          else if (inv_carry) carry_reg <= ~alu_cout;
          else                carry_reg <= alu_cout;
          if (last_nib) begin
            cout_reg   <= alu_cout;
            a_eq_b_reg <= eq_acc_reg & alu_a_eq_b;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_f      = f_reg;
  assign rsp_cout   = cout_reg;
  assign rsp_a_eq_b = a_eq_b_reg;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl: a nibble-level 74181-style ALU model drives the
// DUT's ALU port, and results are compared with a whole-word reference.
module tb_ula_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [3:0]    req_s = 4'h0;
  logic          req_m = 1'b0;
  logic          req_cin = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_f;
  logic          rsp_cout;
  logic          rsp_a_eq_b;
  logic          busy;
  logic [3:0]    alu_a, alu_b, alu_s, alu_f;
  logic          alu_m, alu_cin, alu_cout, alu_a_eq_b;

  int checks = 0;
  int errors = 0;

  ula_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_a_eq_b(rsp_a_eq_b),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_a_eq_b(alu_a_eq_b)
  );

  always #5 clk = ~clk;

  // Arithmetic-mode operands {X, Y}: F = X + Y + carry ("minus 1" = plus all-ones).
  function automatic logic [2*W-1:0] arith_ops(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, ones;
    ones = '1;
    x = a;
    y = '0;
    case (s)
      4'b0000: begin x = a;         y = '0;      end
      4'b0001: begin x = a | b;     y = '0;      end
      4'b0010: begin x = a | ~b;    y = '0;      end
      4'b0011: begin x = '0;        y = ones;    end
      4'b0100: begin x = a;         y = a & ~b;  end
      4'b0101: begin x = a | b;     y = a & ~b;  end
      4'b0110: begin x = a;         y = ~b;      end
      4'b0111: begin x = a & ~b;    y = ones;    end
      4'b1000: begin x = a;         y = a & b;   end
      4'b1001: begin x = a;         y = b;       end
      4'b1010: begin x = a | ~b;    y = a & b;   end
      4'b1011: begin x = a & b;     y = ones;    end
      4'b1100: begin x = a;         y = a;       end
      4'b1101: begin x = a | b;     y = a;       end
      4'b1110: begin x = a | ~b;    y = a;       end
      default: begin x = a;         y = ones;    end
    endcase
    return {x, y};
  endfunction

  function automatic logic [W-1:0] logic_fn(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      4'b0000: return ~a;
      4'b0001: return ~(a | b);
      4'b0010: return ~a & b;
      4'b0011: return '0;
      4'b0100: return ~(a & b);
      4'b0101: return ~b;
      4'b0110: return a ^ b;
      4'b0111: return a & ~b;
      4'b1000: return ~a | b;
      4'b1001: return ~(a ^ b);
      4'b1010: return b;
      4'b1011: return a & b;
      4'b1100: return '1;
      4'b1101: return a | ~b;
      4'b1110: return a | b;
      default: return a;
    endcase
  endfunction

  function automatic logic inv_code(input logic [3:0] s);
    return s inside {4'b0000, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1011};
  endfunction

  // External 4-bit ALU model (combinational).
  logic [2*W-1:0] m_xy;
  logic [W-1:0]   m_lf;
  logic [4:0]     m_sum;
  always_comb begin
    m_xy  = arith_ops(alu_s, {12'h0, alu_a}, {12'h0, alu_b});
    m_lf  = logic_fn(alu_s, {12'h0, alu_a}, {12'h0, alu_b});
    m_sum = {1'b0, m_xy[W+3:W]} + {1'b0, m_xy[3:0]} + {4'b0, alu_cin};
    alu_a_eq_b = (alu_a == alu_b);
    if (alu_m) begin
      alu_f    = m_lf[3:0];
      alu_cout = 1'b0;
    end else begin
      alu_f    = m_sum[3:0];
      alu_cout = m_sum[4] ^ inv_code(alu_s);
    end
  end

  // ALU lines must be quiet outside RUN; carry-in forced to 0 in logic mode.
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy || rsp_valid) begin
        checks++;
        if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'h0) begin
          errors++;
          $display("FAIL alu_idle actual=%h required=0", {alu_a, alu_b, alu_s, alu_m, alu_cin});
        end
      end else if (alu_m) begin
        checks++;
        if (alu_cin !== 1'b0) begin
          errors++;
          $display("FAIL alu_cin_logic actual=%b required=0", alu_cin);
        end
      end
    end
  end

  // One whole operation: request, latency, result, optional stall, release.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input int hold, input logic junk,
                        input string name);
    logic [W:0]     sum;
    logic [2*W-1:0] xy;
    logic [W-1:0]   ef;
    logic           ec, ee;
    int             n;
    if (m) begin
      ef = logic_fn(s, a, b);
      ec = 1'b0;
    end else begin
      xy  = arith_ops(s, a, b);
      sum = {1'b0, xy[2*W-1:W]} + {1'b0, xy[W-1:0]} + {{W{1'b0}}, cin};
      ef  = sum[W-1:0];
      ec  = sum[W] ^ inv_code(s);
    end
    ee = (a == b);

    req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout actual=%b required=1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = junk;
    n = 0;
    while (!rsp_valid && n < 3*NIB) begin
      if (junk) begin req_a = W'($urandom); req_b = W'($urandom); req_s = 4'($urandom); end
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== NIB) begin errors++; $display("FAIL %s_latency actual=%0d required=%0d", name, n, NIB); end
    checks++;
    if (rsp_f !== ef) begin errors++; $display("FAIL %s_f actual=%h required=%h", name, rsp_f, ef); end
    checks++;
    if (rsp_cout !== ec) begin errors++; $display("FAIL %s_cout actual=%b required=%b", name, rsp_cout, ec); end
    checks++;
    if (rsp_a_eq_b !== ee) begin errors++; $display("FAIL %s_eq actual=%b required=%b", name, rsp_a_eq_b, ee); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, req_ready, rsp_f, rsp_cout, rsp_a_eq_b} !== {1'b1, 1'b0, ef, ec, ee}) begin
        errors++;
        $display("FAIL %s_hold actual=%b/%b/%h required=1/0/%h", name, rsp_valid, req_ready, rsp_f, ef);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s_release actual=%b%b required=01", name, rsp_valid, req_ready);
    end
    $display("op %s a=%h b=%h s=%b m=%b cin=%b -> f=%h cout=%b eq=%b", name, a, b, s, m, cin, rsp_f, rsp_cout, rsp_a_eq_b);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_f, rsp_cout, rsp_a_eq_b} !== {3'b000, {W{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_state actual=%b%b%b f=%h required=000 f=0", req_ready, rsp_valid, busy, rsp_f);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release actual=%b%b required=10", req_ready, busy);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 0, 1'b0, "add");
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, 1'b0, "add_wrap");
    run_op(16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b1, 0, 1'b0, "sub_inv");
    run_op(16'hA5A5, 16'hA5A5, 4'b0110, 1'b1, 1'b1, 0, 1'b0, "xor_logic");
  endtask

  task automatic test_hold();
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 3, 1'b1, "hold");
    @(posedge clk); #1;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hold_no_second_op actual=%b%b required=00", busy, rsp_valid);
    end
  endtask

  task automatic test_mid_reset();
    req_a = 16'h1234; req_b = 16'h0FFF; req_s = 4'b1001; req_m = 1'b0; req_cin = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy, req_ready, rsp_f} !== {3'b000, {W{1'b0}}}) begin
      errors++;
      $display("FAIL midrun_reset actual=%b%b%b f=%h required=000 f=0", rsp_valid, busy, req_ready, rsp_f);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL midrun_after actual=%b%b%b required=100", req_ready, busy, rsp_valid);
    end
    // Reset while a result is waiting in DONE.
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (NIB) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL done_reached actual=%b required=1", rsp_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_reset actual=%b%b required=00", rsp_valid, busy);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), (i % 5 == 0) ? 16'h0 : W'($urandom), 4'($urandom), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      run_op(v, v, 4'($urandom), 1'b0, 1'($urandom), 0, 1'b0, "rand_eq");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
